bht_sat_predictor: RTL

- Branch history table for the cv32a60x frontend: per-slot 2-bit saturating counters, indexed by fetch virtual PC.
- Sits downstream of the core configuration (sized by BHTEntries=32, RVC=1, VLEN=32) and upstream of the frontend branch-prediction mux, which consumes its per-slot taken/valid predictions.
- Trained by resolved conditional branches from the execute stage.

---
 rtl/bht_sat_predictor_pkg.sv | 28 ++
 rtl/bht_sat_predictor_sat_counter2_update.sv | 13 +
 rtl/bht_sat_predictor.sv | 66 ++++++
 3 files changed

// File: rtl/bht_sat_predictor_pkg.sv
// bht_sat_predictor_pkg: shared types and geometry helpers for the branch history table
package bht_sat_predictor_pkg;
  typedef struct packed {
    logic [31:0] BHTEntries;
    logic        RVC;
  } bht_cfg_t;
  typedef struct packed {
    logic       valid;
    logic [1:0] cnt;
  } bht_entry_t;
  typedef struct packed {
    logic valid;
    logic taken;
  } bht_prediction_t;
  localparam bht_entry_t BHT_RESET = '{valid: 1'b0, cnt: 2'b01};
  function automatic int instr_per_fetch(input bht_cfg_t c);
    return c.RVC ? 2 : 1;
  endfunction
  function automatic int nr_rows(input bht_cfg_t c);
    return int'(c.BHTEntries) / instr_per_fetch(c);
  endfunction
  function automatic int index_bits(input bht_cfg_t c);
    return $clog2(nr_rows(c));
  endfunction
  function automatic int row_addr_bits(input bht_cfg_t c);
    return $clog2(instr_per_fetch(c));
  endfunction
endpackage

// File: rtl/bht_sat_predictor_sat_counter2_update.sv
// sat_counter2_update: next entry for a trained branch, weak-init when invalid, saturating otherwise
module sat_counter2_update
  import bht_sat_predictor_pkg::*;
(
  input  bht_entry_t cur,
  input  logic       taken,
  output bht_entry_t nxt
);
  assign nxt.valid = 1'b1;
  assign nxt.cnt = !cur.valid ? (taken ? 2'b10 : 2'b01) :
                   taken ? ((cur.cnt == 2'b11) ? 2'b11 : cur.cnt + 2'd1) :
                           ((cur.cnt == 2'b00) ? 2'b00 : cur.cnt - 2'd1);
endmodule

// File: rtl/bht_sat_predictor.sv
// bht_sat_predictor: per-slot 2-bit saturating branch history table indexed by fetch PC
module bht_sat_predictor
  import bht_sat_predictor_pkg::*;
#(
  parameter int VLEN            = 32,
  parameter int BHT_ENTRIES     = 32,
  parameter int INSTR_PER_FETCH = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_bp_i,
  input  logic                       debug_mode_i,
  input  logic [VLEN-1:0]            vpc_i,
  input  logic                       bht_update_valid_i,
  input  logic [VLEN-1:0]            bht_update_pc_i,
  input  logic                       bht_update_taken_i,
  output logic [INSTR_PER_FETCH-1:0] bht_prediction_valid_o,
  output logic [INSTR_PER_FETCH-1:0] bht_prediction_taken_o
);
  localparam bht_cfg_t CFG = '{BHTEntries: BHT_ENTRIES, RVC: (INSTR_PER_FETCH > 1)};
  localparam int NR_ROWS       = nr_rows(CFG);
  localparam int INDEX_BITS    = index_bits(CFG);
  localparam int ROW_ADDR_BITS = row_addr_bits(CFG);
  localparam int SLOT_W        = (ROW_ADDR_BITS > 0) ? ROW_ADDR_BITS : 1;
  localparam int ROW_LSB       = 1 + ROW_ADDR_BITS;
  localparam int TOP_LSB       = ROW_LSB + INDEX_BITS;
  bht_entry_t                mem [NR_ROWS][INSTR_PER_FETCH];
  bht_entry_t                cur, nxt;
  bht_prediction_t           pred [INSTR_PER_FETCH];
  logic [INDEX_BITS-1:0]     rd_row, wr_row;
  logic [SLOT_W-1:0]         wr_slot;
  logic                      upd_en;
  logic                      unused_pc;
  assign rd_row    = vpc_i[ROW_LSB +: INDEX_BITS];
  assign wr_row    = bht_update_pc_i[ROW_LSB +: INDEX_BITS];
  assign wr_slot   = (ROW_ADDR_BITS > 0) ? bht_update_pc_i[1 +: SLOT_W] : '0;
  assign upd_en    = bht_update_valid_i & ~debug_mode_i;
  assign cur       = mem[wr_row][wr_slot];
  assign unused_pc = ^{vpc_i[VLEN-1:TOP_LSB], vpc_i[ROW_LSB-1:0],
                       bht_update_pc_i[VLEN-1:TOP_LSB], bht_update_pc_i[0]};
  sat_counter2_update u_upd (
    .cur  (cur),
    .taken(bht_update_taken_i),
    .nxt  (nxt)
  );
  // reset beats flush beats training; only the addressed slot is written
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int r = 0; r < NR_ROWS; r++)
        for (int s = 0; s < INSTR_PER_FETCH; s++)
          mem[r][s] <= BHT_RESET;
    end else if (flush_bp_i) begin
      for (int r = 0; r < NR_ROWS; r++)
        for (int s = 0; s < INSTR_PER_FETCH; s++)
          mem[r][s].valid <= 1'b0;
    end else if (upd_en) begin
      mem[wr_row][wr_slot] <= nxt;
    end
  end
  for (genvar s = 0; s < INSTR_PER_FETCH; s++) begin : g_slot
    assign pred[s].valid             = mem[rd_row][s].valid;
    assign pred[s].taken             = mem[rd_row][s].valid & mem[rd_row][s].cnt[1];
    assign bht_prediction_valid_o[s] = pred[s].valid;
    assign bht_prediction_taken_o[s] = pred[s].taken;
  end
endmodule
